// File: rtl/sub_mem_sync.sv
// Broadcast-write sync buffer: queues main-core broadcast writes and drains them into local memory.
// Optional macro SUB_MEM_SYNC_FWD_EN forwards pending FIFO data to local reads.
module sub_mem_sync #(
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_DEPTH  = 131072
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bc_u_we,
  input  logic [16:0] bc_u_addr,
  input  logic [31:0] bc_u_din,
  input  logic        bc_l_we,
  input  logic [16:0] bc_l_addr,
  input  logic [31:0] bc_l_din,
  input  logic [16:0] loc_addr,
  input  logic        loc_we,
  input  logic [31:0] loc_din,
  output logic [31:0] loc_dout,
  output logic        sync_stall,
  output logic        sync_pending,
  output logic        sync_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {SYNC, HOLD, ERR} state_t;

  logic [16:0]   fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          stall_q, stall_d;
  logic          pending_q, pending_d;
  logic          ovf_q, ovf_d;
  logic          dout_clr_q;

  logic          pop, push_u, push_l, drop;
  logic [CW-1:0] free_after_pop;
  logic [PW-1:0] wr_idx_l;
  logic [16:0]   drain_addr;
  logic [31:0]   drain_data;
  logic          drain_we, loc_wr;

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   mem_rd_q;

  // Free slots are counted after this cycle's pop, so a full FIFO still accepts one push.
  always_comb begin
    pop            = rstn && (count_q != '0);
    free_after_pop = CW'(FIFO_DEPTH) - count_q + CW'(pop);
    push_u         = rstn && bc_u_we && (free_after_pop != '0);
    push_l         = rstn && bc_l_we && ((free_after_pop - CW'(push_u)) != '0);
    drop           = rstn && ((bc_u_we && !push_u) || (bc_l_we && !push_l));
    wr_idx_l       = wr_ptr_q + PW'(push_u);
    wr_ptr_d       = wr_ptr_q + PW'(push_u) + PW'(push_l);
    rd_ptr_d       = rd_ptr_q + PW'(pop);
    count_d        = count_q - CW'(pop) + CW'(push_u) + CW'(push_l);
    drain_addr     = fifo_addr_q[rd_ptr_q];
    drain_data     = fifo_data_q[rd_ptr_q];
    loc_wr         = rstn && loc_we;
    drain_we       = pop && !(loc_wr && (loc_addr == drain_addr));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (count_d > CW'(FIFO_DEPTH - 2))  state_d = HOLD;
      HOLD:    if (count_d <= CW'(FIFO_DEPTH - 2)) state_d = SYNC;
      ERR:     state_d = ERR;
      default: state_d = SYNC;
    endcase
    if (drop) state_d = ERR;
    stall_d   = (state_d != SYNC);
    pending_d = (count_d != '0);
    ovf_d     = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= SYNC;
      stall_q    <= 1'b0;
      pending_q  <= 1'b0;
      ovf_q      <= 1'b0;
      dout_clr_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      stall_q    <= stall_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      dout_clr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_u) begin
      fifo_addr_q[wr_ptr_q] <= bc_u_addr;
      fifo_data_q[wr_ptr_q] <= bc_u_din;
    end
    if (push_l) begin
      fifo_addr_q[wr_idx_l] <= bc_l_addr;
      fifo_data_q[wr_idx_l] <= bc_l_din;
    end
  end

  // Drain and local ports; a colliding drain write is suppressed so the local write wins.
  always_ff @(posedge clk) begin
    if (drain_we) mem[drain_addr[AW-1:0]] <= drain_data;
    if (loc_wr)   mem[loc_addr[AW-1:0]]   <= loc_din;
    mem_rd_q <= mem[loc_addr[AW-1:0]];
  end

`ifdef SUB_MEM_SYNC_FWD_EN
  logic [FIFO_DEPTH-1:0] ent_match;
  logic [PW-1:0]         ent_idx [FIFO_DEPTH];
  logic                  fwd_hit_d, fwd_hit_q;
  logic [31:0]           fwd_data_d, fwd_data_q;

  // Entries indexed by age: gi = 0 is the oldest (the one being popped this cycle).
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_age
    assign ent_idx[gi]   = rd_ptr_q + PW'(gi);
    assign ent_match[gi] = (CW'(gi) < count_q) && (fifo_addr_q[ent_idx[gi]] == loc_addr);
  end

  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (ent_match[k]) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = fifo_data_q[ent_idx[k]];
      end
    end
    if (push_u && (bc_u_addr == loc_addr)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = bc_u_din;
    end
    if (push_l && (bc_l_addr == loc_addr)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = bc_l_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign loc_dout = dout_clr_q ? 32'h0 : (fwd_hit_q ? fwd_data_q : mem_rd_q);
`else
  assign loc_dout = dout_clr_q ? 32'h0 : mem_rd_q;
`endif

  assign sync_stall    = stall_q;
  assign sync_pending  = pending_q;
  assign sync_overflow = ovf_q;

endmodule
